trap_controller: RTL and testbench

//   Consumer side of the trap countdown: captures the ball when it hits the trap, drives the

---
 rtl/trap_pkg.sv | 17 +
 rtl/frame_cooldown_timer.sv | 42 ++++
 rtl/trap_controller.sv | 113 +++++++++++
 tb/tb_trap_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// trap_pkg
//   Shared types and constants for the trap countdown consumer.
//   trap_state_t : controller FSM states
//   COUNTDOWN_W  : width of the count_down value bus (shared with count_down)
package trap_pkg;

  localparam int COUNTDOWN_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    HOLD     = 3'd2,
    RELEASE  = 3'd3,
    COOLDOWN = 3'd4
  } trap_state_t;

endpackage

// File: rtl/frame_cooldown_timer.sv
// frame_cooldown_timer
//   Counts video-frame pulses after a ball release so the trap stays disarmed
//   for a fixed number of frames.
// Ports
//   clk          in  system clock
//   resetN       in  async active-low reset
//   clear        in  sync abort, empties the counter
//   load         in  preload the counter with FRAMES
//   startOfFrame in  one-clk pulse per video frame
//   done         out high on the frame pulse that consumes the last remaining frame
module frame_cooldown_timer #(
  parameter int FRAMES = 30
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic load,
  input  logic startOfFrame,
  output logic done
);

  localparam int CNT_W = $clog2(FRAMES + 1);

  logic [CNT_W-1:0] countReg;

  // The counter saturates at zero; it is only non-zero while the controller
  // sits in COOLDOWN, so stray frame pulses elsewhere have no effect.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      countReg <= '0;
    end else if (clear) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= CNT_W'(FRAMES);
    end else if (startOfFrame && (countReg != '0)) begin
      countReg <= countReg - CNT_W'(1);
    end
  end

  assign done = startOfFrame && (countReg == CNT_W'(1));

endmodule

// File: rtl/trap_controller.sv
// trap_controller
//   Captures the ball when it hits the trap, runs the external count_down,
//   releases the ball when the countdown reaches zero, then disarms the trap
//   for COOLDOWN_FRAMES frames.
// Ports
//   clk             in  system clock
//   resetN          in  async active-low reset
//   clear           in  sync abort (new game/level)
//   startOfFrame    in  one-clk pulse per video frame
//   ballHitTrap     in  one-clk collision pulse
//   countDownNumber in  current countdown value
//   countDownEnable out to count_down.enable
//   countDownReset  out to count_down.resetCounter
//   ballFreeze      out ball held in trap
//   ballRelease     out one-clk pulse, ball leaves trap
//   trapArmed       out trap accepts a capture
//   showCountdown   out HUD draws countDownNumber
//   captureCount    out saturating capture counter
module trap_controller
  import trap_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 30,
  parameter int CAPTURE_W       = 4
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   clear,
  input  logic                   startOfFrame,
  input  logic                   ballHitTrap,
  input  logic [COUNTDOWN_W-1:0] countDownNumber,
  output logic                   countDownEnable,
  output logic                   countDownReset,
  output logic                   ballFreeze,
  output logic                   ballRelease,
  output logic                   trapArmed,
  output logic                   showCountdown,
  output logic [CAPTURE_W-1:0]   captureCount
);

  trap_state_t          stateReg;
  trap_state_t          stateNext;
  logic [CAPTURE_W-1:0] captureCountReg;
  logic                 cooldownDone;
  logic                 cooldownLoad;

  frame_cooldown_timer #(
    .FRAMES(COOLDOWN_FRAMES)
  ) u_cooldown (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (clear),
    .load        (cooldownLoad),
    .startOfFrame(startOfFrame),
    .done        (cooldownDone)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateReg        <= IDLE;
      captureCountReg <= '0;
    end else if (clear) begin
      stateReg        <= IDLE;
      captureCountReg <= '0;
    end else begin
      stateReg <= stateNext;
      if ((stateReg == IDLE) && ballHitTrap && (captureCountReg != '1)) begin
        captureCountReg <= captureCountReg + CAPTURE_W'(1);
      end
    end
  end

  always_comb begin
    stateNext       = stateReg;
    countDownEnable = 1'b0;
    countDownReset  = 1'b0;
    ballFreeze      = 1'b0;
    ballRelease     = 1'b0;
    trapArmed       = 1'b0;
    showCountdown   = 1'b0;
    cooldownLoad    = 1'b0;
    unique case (stateReg)
      IDLE: begin
        trapArmed = 1'b1;
        if (ballHitTrap) stateNext = LOAD;
      end
      LOAD: begin
        countDownReset = 1'b1;
        ballFreeze     = 1'b1;
        stateNext      = HOLD;
      end
      HOLD: begin
        countDownEnable = 1'b1;
        ballFreeze      = 1'b1;
        showCountdown   = 1'b1;
        // Checked against the live value, so a countdown loaded with 0
        // spends exactly one cycle here.
        if (countDownNumber == '0) stateNext = RELEASE;
      end
      RELEASE: begin
        ballRelease  = 1'b1;
        cooldownLoad = 1'b1;
        stateNext    = COOLDOWN;
      end
      COOLDOWN: begin
        if (cooldownDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign captureCount = captureCountReg;

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;
  import trap_pkg::*;

  localparam int CAP_W = 4;

  logic                   clk = 1'b0;
  logic                   resetN;
  logic                   clear;
  logic                   startOfFrame;
  logic                   ballHitTrap;
  logic [COUNTDOWN_W-1:0] countDownNumber;
  logic                   countDownEnable;
  logic                   countDownReset;
  logic                   ballFreeze;
  logic                   ballRelease;
  logic                   trapArmed;
  logic                   showCountdown;
  logic [CAP_W-1:0]       captureCount;

  // countdown environment model
  logic                   secPulse;
  logic [COUNTDOWN_W-1:0] loadVal;

  int total = 0;
  int bad   = 0;

  trap_controller #(
    .COOLDOWN_FRAMES(3),
    .CAPTURE_W      (CAP_W)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .clear          (clear),
    .startOfFrame   (startOfFrame),
    .ballHitTrap    (ballHitTrap),
    .countDownNumber(countDownNumber),
    .countDownEnable(countDownEnable),
    .countDownReset (countDownReset),
    .ballFreeze     (ballFreeze),
    .ballRelease    (ballRelease),
    .trapArmed      (trapArmed),
    .showCountdown  (showCountdown),
    .captureCount   (captureCount)
  );

  always #5 clk = ~clk;

  // Behavioural count_down: load on resetCounter, decrement on 1 s pulse while enabled.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) countDownNumber <= '0;
    else if (countDownReset) countDownNumber <= loadVal;
    else if (countDownEnable && secPulse && countDownNumber != '0)
      countDownNumber <= countDownNumber - 4'd1;
  end

  // Continuous protocol checks.
  always @(negedge clk) begin
    if (resetN) begin
      total++;
      assert (!(countDownEnable && countDownReset)) else begin
        bad++;
        $error("FAIL en_and_rst observed=%0b%0b expected=not both", countDownEnable, countDownReset);
      end
      total++;
      assert (!ballRelease || dut.stateReg == RELEASE) else begin
        bad++;
        $error("FAIL release_state observed=%0d expected=%0d", dut.stateReg, RELEASE);
      end
      total++;
      assert (!ballFreeze || dut.stateReg == LOAD || dut.stateReg == HOLD) else begin
        bad++;
        $error("FAIL freeze_state observed=%0d expected=LOAD/HOLD", dut.stateReg);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hit();
    ballHitTrap = 1'b1;
    tick();
    ballHitTrap = 1'b0;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  // Three frame pulses finish the cooldown; armed only after the third.
  task automatic drain_cooldown(input string tag);
    frame(); tick();
    frame(); tick();
    chk({tag, "_armed_before_3rd"}, {7'd0, trapArmed}, 8'd0);
    frame();
    chk({tag, "_armed_after_3rd"}, {7'd0, trapArmed}, 8'd1);
  endtask

  initial begin
    resetN = 1'b0; clear = 1'b0; startOfFrame = 1'b0; ballHitTrap = 1'b0;
    secPulse = 1'b0; loadVal = 4'd3;

    // 1: reset state
    tick(); tick();
    chk("rst_armed",   {7'd0, trapArmed},   8'd1);
    chk("rst_freeze",  {7'd0, ballFreeze},  8'd0);
    chk("rst_release", {7'd0, ballRelease}, 8'd0);
    chk("rst_count",   {4'd0, captureCount}, 8'd0);
    chk("rst_state",   {5'd0, dut.stateReg}, {5'd0, IDLE});
    $display("reset: armed=%0b count=%0d", trapArmed, captureCount);
    resetN = 1'b1;
    tick();

    // 2: capture with countdown of 3
    hit();
    chk("t2_load_rst",   {7'd0, countDownReset},  8'd1);
    chk("t2_load_en",    {7'd0, countDownEnable}, 8'd0);
    chk("t2_load_frz",   {7'd0, ballFreeze},      8'd1);
    chk("t2_load_arm",   {7'd0, trapArmed},       8'd0);
    chk("t2_count",      {4'd0, captureCount},    8'd1);
    tick();
    chk("t2_hold_en",    {7'd0, countDownEnable}, 8'd1);
    chk("t2_hold_rst",   {7'd0, countDownReset},  8'd0);
    chk("t2_hold_show",  {7'd0, showCountdown},   8'd1);
    chk("t2_hold_val",   {4'd0, countDownNumber}, 8'd3);
    for (int k = 0; k < 3; k++) begin
      tick(); tick(); tick();
      chk("t2_hold_frz", {7'd0, ballFreeze}, 8'd1);
      secPulse = 1'b1;
      tick();
      secPulse = 1'b0;
      chk("t2_val", {4'd0, countDownNumber}, 8'(2 - k));
      chk("t2_no_rel", {7'd0, ballRelease}, 8'd0);
    end
    tick();
    chk("t2_rel",     {7'd0, ballRelease}, 8'd1);
    chk("t2_rel_frz", {7'd0, ballFreeze},  8'd0);
    chk("t2_rel_en",  {7'd0, countDownEnable}, 8'd0);
    $display("capture1: release seen=%0b count=%0d", ballRelease, captureCount);
    tick();
    chk("t2_rel_pulse", {7'd0, ballRelease}, 8'd0);

    // 4: cooldown ignores hits
    hit();
    chk("t4_ign_count", {4'd0, captureCount}, 8'd1);
    chk("t4_ign_frz",   {7'd0, ballFreeze},   8'd0);
    tick();
    chk("t4_ign_rst",   {7'd0, countDownReset}, 8'd0);
    drain_cooldown("t4");
    $display("cooldown: armed=%0b count=%0d", trapArmed, captureCount);

    // 3: countdown loaded with 0
    loadVal = 4'd0;
    hit();
    chk("t3_load_rst", {7'd0, countDownReset}, 8'd1);
    tick();
    chk("t3_hold_en",  {7'd0, countDownEnable}, 8'd1);
    chk("t3_hold_val", {4'd0, countDownNumber}, 8'd0);
    tick();
    chk("t3_rel",      {7'd0, ballRelease}, 8'd1);
    chk("t3_rel_en",   {7'd0, countDownEnable}, 8'd0);
    tick();
    chk("t3_cd_en",    {7'd0, countDownEnable}, 8'd0);
    chk("t3_cd_rel",   {7'd0, ballRelease}, 8'd0);
    drain_cooldown("t3");
    $display("zero load: count=%0d", captureCount);

    // 5: clear during HOLD
    loadVal = 4'd5;
    hit();
    tick();
    chk("t5_hold_frz", {7'd0, ballFreeze}, 8'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_armed", {7'd0, trapArmed},   8'd1);
    chk("t5_frz",   {7'd0, ballFreeze},  8'd0);
    chk("t5_count", {4'd0, captureCount}, 8'd0);
    chk("t5_rel",   {7'd0, ballRelease}, 8'd0);
    tick();
    chk("t5_rel2",  {7'd0, ballRelease}, 8'd0);
    $display("clear: armed=%0b count=%0d", trapArmed, captureCount);

    // async reset mid-HOLD unfreezes without a clock edge
    hit();
    tick();
    #2;
    resetN = 1'b0;
    #1;
    chk("ar_frz",   {7'd0, ballFreeze},  8'd0);
    chk("ar_armed", {7'd0, trapArmed},   8'd1);
    chk("ar_count", {4'd0, captureCount}, 8'd0);
    $display("async reset: freeze=%0b", ballFreeze);
    tick();
    resetN = 1'b1;
    tick();

    // 6: saturation of captureCount
    loadVal = 4'd0;
    for (int i = 0; i < 16; i++) begin
      hit();
      chk("t6_count", {4'd0, captureCount}, (i + 1 > 15) ? 8'd15 : 8'(i + 1));
      tick(); tick(); tick();
      drain_cooldown("t6");
      $display("capture %0d: count=%0d", i + 1, captureCount);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
